// File: rtl/lock_pkg.sv
// Shared types and helpers for the keypad lock controller.
package lock_pkg;

    // Controller states.
    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        OPEN,
        FAIL,
        LOCKOUT
    } state_t;

    // Non-digit key codes with a meaning; every other non-digit code is ignored.
    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hF;

    // Bits needed to index 'value' distinct items (never less than one bit).
    function automatic int clog2w(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Keys 0x0..0x9 are code digits.
    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/lock_ctrl_multi_if.sv
// Keypad / status bundle between the keypad scanner side and the lock controller.
interface lock_ctrl_multi_if #(
    parameter int DIGITS = 4,
    parameter int NPROF  = 4
) ();
    localparam int PSEL_W = lock_pkg::clog2w(NPROF);
    localparam int CNT_W  = lock_pkg::clog2w(DIGITS) + 1;
    localparam int CODE_W = 4 * DIGITS;

    logic              key_valid;
    logic [3:0]        key_code;
    logic              add_profile;
    logic [PSEL_W-1:0] prof_sel;
    logic              tamper_in;
    logic              valid;
    logic              fail_pulse;
    logic              enrolled;
    logic              lockout;
    logic              locked;
    logic [CNT_W-1:0]  digit_cnt;
    logic [CODE_W-1:0] entry_disp;

    // Scanner / board side: drives keys and tamper, observes status.
    modport master (
        output key_valid, key_code, add_profile, prof_sel, tamper_in,
        input  valid, fail_pulse, enrolled, lockout, locked, digit_cnt, entry_disp
    );

    // Lock controller side.
    modport slave (
        input  key_valid, key_code, add_profile, prof_sel, tamper_in,
        output valid, fail_pulse, enrolled, lockout, locked, digit_cnt, entry_disp
    );
endinterface

// File: rtl/lock_ctrl_multi_tamper_filter.sv
// Run-length filter on the raw tamper input with a sticky latch.
module tamper_filter
    import lock_pkg::*;
#(
    parameter int TAMPER_LEN = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic tamper_in,
    output logic locked,
    output logic locked_next
);
    localparam int RUN_W = clog2w(TAMPER_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(TAMPER_LEN);

    logic [RUN_W-1:0] run_q, run_d;
    logic             locked_q, locked_d;

    // Count consecutive high samples, saturating; latch once the run is long enough.
    always_comb begin
        run_d = '0;
        if (tamper_in) begin
            run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
        end
        locked_d = locked_q | (run_d == RUN_MAX);
    end

    // Filter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            run_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            run_q    <= run_d;
            locked_q <= locked_d;
        end
    end

    assign locked      = locked_q;
    // Lets the controller see a latch happening on the same edge as its decision.
    assign locked_next = locked_d;
endmodule

// File: rtl/lock_ctrl_multi.sv
// Keypad lock controller: code entry, profile check/enroll, fail lockout, tamper.
module lock_ctrl_multi
    import lock_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int NPROF       = 4,
    parameter int MAX_FAIL    = 3,
    parameter int LOCKOUT_CYC = 1024,
    parameter int OPEN_CYC    = 256,
    parameter int TIMEOUT_CYC = 4096,
    parameter int TAMPER_LEN  = 16
) (
    input logic               clk,
    input logic               rst,
    lock_ctrl_multi_if.slave  bus
);
    localparam int CODE_W  = 4 * DIGITS;
    localparam int CNT_W   = clog2w(DIGITS) + 1;
    localparam int PSEL_W  = clog2w(NPROF);
    localparam int FAIL_W  = clog2w(MAX_FAIL + 1);
    localparam int TMR_MAX = (LOCKOUT_CYC > OPEN_CYC)
                           ? ((LOCKOUT_CYC > TIMEOUT_CYC) ? LOCKOUT_CYC : TIMEOUT_CYC)
                           : ((OPEN_CYC > TIMEOUT_CYC) ? OPEN_CYC : TIMEOUT_CYC);
    localparam int TMR_W   = clog2w(TMR_MAX);

    localparam logic [CNT_W-1:0]  FULL_CNT     = CNT_W'(DIGITS);
    localparam logic [TMR_W-1:0]  OPEN_LAST    = TMR_W'(OPEN_CYC - 1);
    localparam logic [TMR_W-1:0]  LOCK_LAST    = TMR_W'(LOCKOUT_CYC - 1);
    localparam logic [TMR_W-1:0]  TIMEOUT_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [FAIL_W-1:0] FAIL_SAT     = FAIL_W'(MAX_FAIL);

    state_t            state_q, state_d;
    logic [CODE_W-1:0] entry_q, entry_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [FAIL_W-1:0] fail_cnt_q, fail_cnt_d;
    logic              add_q, add_d;
    logic [PSEL_W-1:0] sel_q, sel_d;
    logic              valid_q, valid_d;
    logic              fail_pulse_q, fail_pulse_d;
    logic              enrolled_q, enrolled_d;
    logic              lockout_q, lockout_d;

    logic              tamper_locked;
    logic              tamper_locked_next;
    logic [CODE_W-1:0] prof_rd [NPROF];
    logic              chk_short;
    logic              chk_match;
    logic              prof_we;

    tamper_filter #(
        .TAMPER_LEN (TAMPER_LEN)
    ) u_tamper (
        .clk         (clk),
        .rst         (rst),
        .tamper_in   (bus.tamper_in),
        .locked      (tamper_locked),
        .locked_next (tamper_locked_next)
    );

    // CHECK decision inputs; a tamper latching this very edge already counts.
    assign chk_short = (cnt_q < FULL_CNT);
    assign chk_match = (entry_q == prof_rd[sel_q]);
    assign prof_we   = (state_q == CHECK) && add_q && !chk_short && !tamper_locked_next;

    // Profile slots: reset to the all-zero default code, written only by enrollment.
    for (genvar gi = 0; gi < NPROF; gi++) begin : g_slot
        logic [CODE_W-1:0] slot_q, slot_d;

        // Select the new code when this slot is the enrollment target.
        always_comb begin
            slot_d = slot_q;
            if (prof_we && (sel_q == PSEL_W'(gi))) begin
                slot_d = entry_q;
            end
        end

        // Slot storage.
        always_ff @(posedge clk) begin
            if (!rst) begin
                slot_q <= '0;
            end else begin
                slot_q <= slot_d;
            end
        end

        assign prof_rd[gi] = slot_q;
    end

    // Next-state and next-output logic; outputs are registered alongside the state.
    always_comb begin
        state_d      = state_q;
        entry_d      = entry_q;
        cnt_d        = cnt_q;
        tmr_d        = tmr_q;
        fail_cnt_d   = fail_cnt_q;
        add_d        = add_q;
        sel_d        = sel_q;
        valid_d      = 1'b0;
        fail_pulse_d = 1'b0;
        enrolled_d   = 1'b0;
        lockout_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.key_valid && is_digit(bus.key_code)) begin
                    state_d = ENTRY;
                    entry_d = CODE_W'(bus.key_code);
                    cnt_d   = CNT_W'(1);
                    tmr_d   = '0;
                end
            end

            ENTRY: begin
                if (bus.key_valid) begin
                    // Any key restarts the inactivity timer, and wins over expiry.
                    tmr_d = '0;
                    if (is_digit(bus.key_code)) begin
                        if (cnt_q < FULL_CNT) begin
                            entry_d = {entry_q[CODE_W-5:0], bus.key_code};
                            cnt_d   = cnt_q + CNT_W'(1);
                        end
                    end else if (bus.key_code == KEY_CLEAR) begin
                        state_d = IDLE;
                        entry_d = '0;
                        cnt_d   = '0;
                    end else if (bus.key_code == KEY_ENTER) begin
                        state_d = CHECK;
                        add_d   = bus.add_profile;
                        sel_d   = bus.prof_sel;
                    end
                end else if (tmr_q == TIMEOUT_LAST) begin
                    state_d = IDLE;
                    entry_d = '0;
                    cnt_d   = '0;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end

            CHECK: begin
                entry_d = '0;
                cnt_d   = '0;
                tmr_d   = '0;
                if (chk_short || tamper_locked_next) begin
                    state_d      = FAIL;
                    fail_pulse_d = 1'b1;
                end else if (add_q) begin
                    state_d    = IDLE;
                    enrolled_d = 1'b1;
                end else if (chk_match) begin
                    state_d    = OPEN;
                    valid_d    = 1'b1;
                    fail_cnt_d = '0;
                end else begin
                    state_d      = FAIL;
                    fail_pulse_d = 1'b1;
                end
            end

            OPEN: begin
                if (tamper_locked || (tmr_q == OPEN_LAST)) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end else begin
                    valid_d = 1'b1;
                    tmr_d   = tmr_q + TMR_W'(1);
                end
            end

            FAIL: begin
                tmr_d = '0;
                if (int'(fail_cnt_q) + 1 >= MAX_FAIL) begin
                    state_d    = LOCKOUT;
                    fail_cnt_d = FAIL_SAT;
                    lockout_d  = 1'b1;
                end else begin
                    state_d    = IDLE;
                    fail_cnt_d = fail_cnt_q + FAIL_W'(1);
                end
            end

            LOCKOUT: begin
                if (tmr_q == LOCK_LAST) begin
                    state_d    = IDLE;
                    fail_cnt_d = '0;
                    tmr_d      = '0;
                end else begin
                    lockout_d = 1'b1;
                    tmr_d     = tmr_q + TMR_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                entry_d = '0;
                cnt_d   = '0;
                tmr_d   = '0;
            end
        endcase
    end

    // Controller state, timers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            entry_q      <= '0;
            cnt_q        <= '0;
            tmr_q        <= '0;
            fail_cnt_q   <= '0;
            add_q        <= 1'b0;
            sel_q        <= '0;
            valid_q      <= 1'b0;
            fail_pulse_q <= 1'b0;
            enrolled_q   <= 1'b0;
            lockout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            entry_q      <= entry_d;
            cnt_q        <= cnt_d;
            tmr_q        <= tmr_d;
            fail_cnt_q   <= fail_cnt_d;
            add_q        <= add_d;
            sel_q        <= sel_d;
            valid_q      <= valid_d;
            fail_pulse_q <= fail_pulse_d;
            enrolled_q   <= enrolled_d;
            lockout_q    <= lockout_d;
        end
    end

    assign bus.valid      = valid_q;
    assign bus.fail_pulse = fail_pulse_q;
    assign bus.enrolled   = enrolled_q;
    assign bus.lockout    = lockout_q;
    assign bus.locked     = tamper_locked;
    // The entry is only shown while it is being typed.
    assign bus.digit_cnt  = (state_q == ENTRY) ? cnt_q : '0;
    assign bus.entry_disp = (state_q == ENTRY) ? entry_q : '0;
endmodule

// File: tb/tb_lock_ctrl_multi.sv
// Directed bench for lock_ctrl_multi with immediate-assertion checks.
module tb_lock_ctrl_multi;
    import lock_pkg::*;

    localparam int DIGITS      = 4;
    localparam int NPROF       = 4;
    localparam int MAX_FAIL    = 3;
    localparam int LOCKOUT_CYC = 1024;
    localparam int OPEN_CYC    = 256;
    localparam int TIMEOUT_CYC = 4096;
    localparam int TAMPER_LEN  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;
    int   run_len;

    always #5 clk = ~clk;

    lock_ctrl_multi_if #(.DIGITS(DIGITS), .NPROF(NPROF)) bus ();

    lock_ctrl_multi #(
        .DIGITS      (DIGITS),
        .NPROF       (NPROF),
        .MAX_FAIL    (MAX_FAIL),
        .LOCKOUT_CYC (LOCKOUT_CYC),
        .OPEN_CYC    (OPEN_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TAMPER_LEN  (TAMPER_LEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle key strobe, sampled on the next edge.
    task automatic press(input logic [3:0] k);
        bus.key_valid = 1'b1;
        bus.key_code  = k;
        tick(1);
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
    endtask

    // Type n digits (most significant nibble first), then enter.
    task automatic enter_code(input logic [31:0] code, input int n,
                              input logic add, input logic [1:0] sel);
        for (int i = n - 1; i >= 0; i--) begin
            press(code[4*i +: 4]);
        end
        bus.add_profile = add;
        bus.prof_sel    = sel;
        press(KEY_ENTER);
        bus.add_profile = 1'b0;
    endtask

    // Count consecutive sampled cycles with valid high (bounded).
    task automatic valid_run(output int n);
        n = 0;
        while (bus.valid === 1'b1 && n < 2000) begin
            n++;
            tick(1);
        end
    endtask

    initial begin
        bus.key_valid   = 1'b0;
        bus.key_code    = 4'h0;
        bus.add_profile = 1'b0;
        bus.prof_sel    = 2'd0;
        bus.tamper_in   = 1'b0;
        rst             = 1'b0;
        tick(3);

        // Reset state.
        check("rst_valid",      32'(bus.valid), 0);
        check("rst_fail_pulse", 32'(bus.fail_pulse), 0);
        check("rst_enrolled",   32'(bus.enrolled), 0);
        check("rst_lockout",    32'(bus.lockout), 0);
        check("rst_locked",     32'(bus.locked), 0);
        check("rst_digit_cnt",  32'(bus.digit_cnt), 0);
        check("rst_entry_disp", 32'(bus.entry_disp), 0);
        rst = 1'b1;
        tick(1);

        // Default all-zero code on slot 0.
        press(4'h0);
        check("first_digit_cnt", 32'(bus.digit_cnt), 1);
        press(4'h0); press(4'h0); press(4'h0);
        check("four_digit_cnt", 32'(bus.digit_cnt), 4);
        bus.prof_sel = 2'd0;
        press(KEY_ENTER);
        check("check_cycle_valid", 32'(bus.valid), 0);
        check("check_cycle_disp",  32'(bus.entry_disp), 0);
        tick(1);
        check("open0_valid",      32'(bus.valid), 1);
        check("open0_fail_pulse", 32'(bus.fail_pulse), 0);
        check("open0_enrolled",   32'(bus.enrolled), 0);
        check("open0_lockout",    32'(bus.lockout), 0);
        valid_run(run_len);
        check("open0_len", 32'(run_len), 256);

        // Enroll slot 2 with 1234.
        enter_code(32'h1234, 4, 1'b1, 2'd2);
        tick(1);
        check("enroll_pulse", 32'(bus.enrolled), 1);
        check("enroll_valid", 32'(bus.valid), 0);
        tick(1);
        check("enroll_pulse_end", 32'(bus.enrolled), 0);

        // Verify slot 2 with 1234.
        enter_code(32'h1234, 4, 1'b0, 2'd2);
        tick(1);
        check("verify2_valid", 32'(bus.valid), 1);
        valid_run(run_len);
        check("verify2_len", 32'(run_len), 256);

        // Same code on slot 1 (still zero) fails.
        enter_code(32'h1234, 4, 1'b0, 2'd1);
        tick(1);
        check("verify1_fail", 32'(bus.fail_pulse), 1);
        check("verify1_valid", 32'(bus.valid), 0);
        tick(1);
        check("verify1_fail_end", 32'(bus.fail_pulse), 0);

        // A correct open clears the failure count before the lockout run.
        enter_code(32'h0000, 4, 1'b0, 2'd0);
        tick(1);
        check("clear_cnt_valid", 32'(bus.valid), 1);
        valid_run(run_len);

        // Three wrong codes -> lockout.
        for (int a = 1; a <= 3; a++) begin
            enter_code(32'h9999, 4, 1'b0, 2'd2);
            tick(1);
            check($sformatf("wrong%0d_fail", a), 32'(bus.fail_pulse), 1);
            check($sformatf("wrong%0d_lockout", a), 32'(bus.lockout), 0);
            tick(1);
        end
        check("lockout_start", 32'(bus.lockout), 1);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'h1;
        run_len = 0;
        while (bus.lockout === 1'b1 && run_len < 2000) begin
            run_len++;
            tick(1);
            if (run_len == 1) begin
                bus.key_valid = 1'b0;
                bus.key_code  = 4'h0;
                check("lockout_key_ignored", 32'(bus.digit_cnt), 0);
            end
        end
        check("lockout_len", 32'(run_len), 1024);
        check("after_lockout_cnt", 32'(bus.digit_cnt), 0);
        enter_code(32'h1234, 4, 1'b0, 2'd2);
        tick(1);
        check("after_lockout_valid", 32'(bus.valid), 1);
        valid_run(run_len);

        // Short code fails; extra digits ignored when full; clear empties entry.
        enter_code(32'h12, 2, 1'b0, 2'd2);
        tick(1);
        check("short_fail", 32'(bus.fail_pulse), 1);
        check("short_valid", 32'(bus.valid), 0);
        tick(1);
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
        check("full_digit_cnt",  32'(bus.digit_cnt), 4);
        check("full_entry_disp", 32'(bus.entry_disp), 32'h1234);
        press(KEY_CLEAR);
        check("clear_digit_cnt",  32'(bus.digit_cnt), 0);
        check("clear_entry_disp", 32'(bus.entry_disp), 0);

        // Tamper filter: 15 highs do not latch, 16 do.
        bus.tamper_in = 1'b1;
        tick(15);
        bus.tamper_in = 1'b0;
        check("tamper15_locked", 32'(bus.locked), 0);
        tick(1);
        check("tamper15_after", 32'(bus.locked), 0);
        bus.tamper_in = 1'b1;
        tick(15);
        check("tamper_pre16", 32'(bus.locked), 0);
        tick(1);
        check("tamper16_locked", 32'(bus.locked), 1);
        bus.tamper_in = 1'b0;
        tick(3);
        check("tamper_sticky", 32'(bus.locked), 1);
        enter_code(32'h1234, 4, 1'b0, 2'd2);
        tick(1);
        check("locked_match_fail",  32'(bus.fail_pulse), 1);
        check("locked_match_valid", 32'(bus.valid), 0);
        tick(1);
        check("locked_no_open", 32'(bus.valid), 0);

        // Entry timeout: discarded silently after 4096 idle cycles.
        press(4'h1); press(4'h2);
        tick(TIMEOUT_CYC - 1);
        check("timeout_pre_cnt", 32'(bus.digit_cnt), 2);
        tick(1);
        check("timeout_cnt",  32'(bus.digit_cnt), 0);
        check("timeout_fail", 32'(bus.fail_pulse), 0);

        // Reset clears the tamper latch.
        rst = 1'b0;
        tick(1);
        check("rst2_locked", 32'(bus.locked), 0);
        rst = 1'b1;

        // Enroll slot 3, open with it, then reset mid-OPEN.
        enter_code(32'h5678, 4, 1'b1, 2'd3);
        tick(1);
        check("enroll3_pulse", 32'(bus.enrolled), 1);
        tick(1);
        enter_code(32'h5678, 4, 1'b0, 2'd3);
        tick(1);
        check("open3_valid", 32'(bus.valid), 1);
        tick(10);
        check("open3_mid_valid", 32'(bus.valid), 1);
        rst = 1'b0;
        tick(1);
        check("rst_open_valid", 32'(bus.valid), 0);
        rst = 1'b1;

        // Slot 3 is back to the all-zero default.
        enter_code(32'h0000, 4, 1'b0, 2'd3);
        tick(1);
        check("slot3_zero_valid", 32'(bus.valid), 1);
        valid_run(run_len);
        enter_code(32'h5678, 4, 1'b0, 2'd3);
        tick(1);
        check("slot3_old_fail", 32'(bus.fail_pulse), 1);
        check("slot3_old_valid", 32'(bus.valid), 0);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
